downscale_2x2_avg: RTL
======================

Name: downscale_2x2_avg

Overview:
- Consumes the RGB pixel stream produced by the image input stage: horizontal_sync high marks a valid pixel, rows arrive in raster order, and blanking gaps separate the rows.
- Halves resolution in both axes by averaging each 2x2 pixel block per channel, with rounding.
- Uses a one-row line buffer of pair sums.
- Emits a valid-qualified downscaled stream with coordinates, for the output writer stage.

Parameters:
- WIDTH, 768, input pixels per row; must be even and >= 2.
- HEIGHT, 512, input rows per frame; must be even and >= 2.

Ports:
- horizontal_clock  input  1  pixel clock; all state updates on rising edge.
- horizontal_reset  input  1  asynchronous, active-low reset.
- horizontal_sync  input  1  input pixel valid; r/g/b are sampled only on rising edges where this is high.
- r  input  8  input red.
- g  input  8  input green.
- b  input  8  input blue.
- out_valid  output  1  registered; one-cycle strobe per output pixel.
- out_r  output  8  averaged red.
- out_g  output  8  averaged green.
- out_b  output  8  averaged blue.
- out_x  output  11  output column, 0..WIDTH/2-1.
- out_y  output  11  output row, 0..HEIGHT/2-1.
- row_end  output  1  high together with out_valid on the last pixel of each output row.
- frame_done  output  1  one-cycle pulse, coincident with the final out_valid of a frame.

Behaviour:
- Reset (horizontal_reset low, async):
  - All outputs go to 0.
  - Column counter, row counter, pair-hold registers and state go to 0 / EVEN_ROW.
  - Line buffer contents are not reset; they are always written before being read.
- Counters:
  - col (11 bit) and row (11 bit) advance only on accepted pixels.
  - At col==WIDTH-1: col wraps to 0 and row increments.
  - At row==HEIGHT-1 with col==WIDTH-1: row wraps to 0 and a new frame starts with the next accepted pixel.
- Gaps:
  - horizontal_sync low at any point, including mid-row, pauses all counters and holds state.
  - A gap mid-row is not an error, and the output is identical to the gapless case.
- Even-column pixel (col[0]==0): latch r/g/b into 8-bit hold registers.
- Odd-column pixel:
  - Form pair sums of 9 bits per channel: hold + input.
- States: EVEN_ROW, ODD_ROW; the state mirrors row[0].
  - EVEN_ROW, odd column: write the pair sums to linebuf[col>>1]. The buffer has WIDTH/2 entries x 27 bits. No output.
  - EVEN_ROW -> ODD_ROW on the accepted pixel with col==WIDTH-1.
  - ODD_ROW, odd column: total = linebuf[col>>1] + pair sum, giving 10 bits per channel. Result = (total + 2) >> 2, truncated to 8 bits; the maximum is (1020+2)>>2 = 255, so there is no overflow.
  - ODD_ROW -> EVEN_ROW on col==WIDTH-1.
- Output registration:
  - On the rising edge that accepts the odd-row, odd-column input, out_r/g/b, out_x=col>>1 and out_y=row>>1 are registered and out_valid goes high.
  - Latency: output visible in the cycle after the 4th pixel of the block is sampled.
  - out_valid returns to 0 the next cycle unless another block completes.
  - The peak rate is one output per two input pixels.
- Data outputs hold their last values while out_valid is low.
- row_end is asserted with out_valid when col==WIDTH-1 on an odd row.
- frame_done is additionally asserted when row==HEIGHT-1 as well.
- Reset mid-frame:
  - All progress is discarded and no further output is produced for the partial frame.
  - The next accepted pixel after reset release is treated as row 0, col 0.
- There is no backpressure; the downstream stage must accept every out_valid strobe.

Test Plan:
- Bench uses WIDTH=4, HEIGHT=4, gapless rows separated by 160-cycle hsync-low gaps.
  - Stimulus: all pixels r=g=b=100.
  - Required: exactly 4 out_valid strobes, each 100/100/100, with (x,y) = (0,0),(1,0),(0,1),(1,1).
  - row_end on x=1; frame_done only on (1,1).
- Rounding:
  - Block (0,0) red values 1,2 / 1,2 gives out_r=2.
  - Block (1,0) red values 0,0 / 0,1 gives out_r=0.
  - Block (0,1) red values 0,1 / 0,1 gives out_r=1.
  - Green and blue are checked independently with swapped patterns.
- Saturation boundary: all 255 -> every output 255; all 0 -> every output 0.
- Mid-row gap: insert 5 low cycles between col1 and col2 of every row.
  - Required: output values and coordinates are identical to the gapless run.
  - out_valid timing shifts only by the gap.
- Reset mid-frame: assert reset after row 2, col 1.
  - Required: all outputs 0 immediately; no out_valid during the rest of the partial frame.
  - A subsequent full frame of 50s yields 4 outputs of 50 starting at (0,0).
- Back-to-back frames: frame A constant 10, frame B constant 200, with one gap between them.
  - Required: 4 outputs of 10 followed by 4 of 200; out_y restarts at 0; frame_done pulses twice.

Source files
------------

// File: rtl/downscale_2x2_avg.sv
// downscale_2x2_avg
//   Halves an RGB raster stream in both axes by averaging each 2x2 block
//   per channel with round-half-up: (sum of 4 + 2) >> 2.
//   Even rows store horizontal pair sums in a one-row line buffer; odd rows
//   add their own pair sums to the stored ones and emit one output pixel.
//
// Ports
//   horizontal_clock  pixel clock, rising edge
//   horizontal_reset  asynchronous, active-low reset
//   horizontal_sync   input pixel valid (r/g/b sampled when high)
//   r, g, b           input pixel, 8 bit per channel
//   out_valid         one-cycle strobe per output pixel (registered)
//   out_r/g/b         averaged pixel, held while out_valid is low
//   out_x, out_y      output coordinates, held while out_valid is low
//   row_end           with out_valid on the last pixel of an output row
//   frame_done        with out_valid on the last pixel of a frame
//   state_dbg         current row-parity state (0 EVEN_ROW, 1 ODD_ROW)
//
// Handshake: out_valid is a pure strobe with no ready; the consumer must
// take every strobe. The input side is likewise valid-only: a pixel is
// accepted on every rising edge where horizontal_sync is high, and low
// cycles anywhere (including mid-row) simply freeze all state.
module downscale_2x2_avg #(
  parameter int WIDTH  = 768,
  parameter int HEIGHT = 512
) (
  input  logic        horizontal_clock,
  input  logic        horizontal_reset,
  input  logic        horizontal_sync,
  input  logic [7:0]  r,
  input  logic [7:0]  g,
  input  logic [7:0]  b,
  output logic        out_valid,
  output logic [7:0]  out_r,
  output logic [7:0]  out_g,
  output logic [7:0]  out_b,
  output logic [10:0] out_x,
  output logic [10:0] out_y,
  output logic        row_end,
  output logic        frame_done,
  output logic        state_dbg
);

  localparam int HALF = WIDTH / 2;
  localparam int AW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [10:0] COL_LAST = 11'(WIDTH - 1);
  localparam logic [10:0] ROW_LAST = 11'(HEIGHT - 1);

  typedef enum logic {
    EVEN_ROW = 1'b0,
    ODD_ROW  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [10:0] col_q, row_q;
  logic [7:0]  hold_r_q, hold_g_q, hold_b_q;

  // Pair sums packed {r[8:0], g[8:0], b[8:0]}; never reset because every
  // entry is written on an even row before the odd row reads it.
  logic [26:0] linebuf [HALF];

  logic        col_last, row_last;
  logic        lb_we, fire;
  logic [8:0]  pair_r, pair_g, pair_b;
  logic [26:0] lb_word;
  logic [9:0]  total_r, total_g, total_b;
  logic [7:0]  avg_r, avg_g, avg_b;
  logic [AW-1:0] lb_idx;

  assign col_last  = (col_q == COL_LAST);
  assign row_last  = (row_q == ROW_LAST);
  assign lb_idx    = col_q[AW:1];
  assign lb_word   = linebuf[lb_idx];
  assign state_dbg = state_q;

  // Datapath: pair sums and the rounded 2x2 average.
  always_comb begin
    pair_r  = {1'b0, hold_r_q} + {1'b0, r};
    pair_g  = {1'b0, hold_g_q} + {1'b0, g};
    pair_b  = {1'b0, hold_b_q} + {1'b0, b};
    total_r = {1'b0, lb_word[26:18]} + {1'b0, pair_r};
    total_g = {1'b0, lb_word[17:9]}  + {1'b0, pair_g};
    total_b = {1'b0, lb_word[8:0]}   + {1'b0, pair_b};
    // Largest total is 1020, so +2 still fits in 10 bits.
    avg_r   = 8'((total_r + 10'd2) >> 2);
    avg_g   = 8'((total_g + 10'd2) >> 2);
    avg_b   = 8'((total_b + 10'd2) >> 2);
  end

  // FSM next state and control strobes.
  always_comb begin
    state_d = state_q;
    lb_we   = 1'b0;
    fire    = 1'b0;
    if (horizontal_sync && col_q[0]) begin
      if (state_q == EVEN_ROW) lb_we = 1'b1;
      else                     fire  = 1'b1;
    end
    if (horizontal_sync && col_last) begin
      state_d = (state_q == EVEN_ROW) ? ODD_ROW : EVEN_ROW;
    end
  end

  always_ff @(posedge horizontal_clock or negedge horizontal_reset) begin
    if (!horizontal_reset) begin
      state_q  <= EVEN_ROW;
      col_q    <= '0;
      row_q    <= '0;
      hold_r_q <= '0;
      hold_g_q <= '0;
      hold_b_q <= '0;
    end else begin
      state_q <= state_d;
      if (horizontal_sync) begin
        if (col_last) begin
          col_q <= '0;
          row_q <= row_last ? 11'd0 : row_q + 11'd1;
        end else begin
          col_q <= col_q + 11'd1;
        end
        if (!col_q[0]) begin
          hold_r_q <= r;
          hold_g_q <= g;
          hold_b_q <= b;
        end
      end
    end
  end

  always_ff @(posedge horizontal_clock) begin
    if (lb_we) linebuf[lb_idx] <= {pair_r, pair_g, pair_b};
  end

  always_ff @(posedge horizontal_clock or negedge horizontal_reset) begin
    if (!horizontal_reset) begin
      out_valid  <= 1'b0;
      out_r      <= '0;
      out_g      <= '0;
      out_b      <= '0;
      out_x      <= '0;
      out_y      <= '0;
      row_end    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= fire;
      row_end    <= fire && col_last;
      frame_done <= fire && col_last && row_last;
      if (fire) begin
        out_r <= avg_r;
        out_g <= avg_g;
        out_b <= avg_b;
        out_x <= col_q >> 1;
        out_y <= row_q >> 1;
      end
    end
  end

endmodule
